// File: rtl/control_cmd_pkg.sv
// -----------------------------------------------------------------------------
// control_cmd_pkg
// Shared definitions for the UART command engine: FSM state encoding,
// command characters and a constant clog2 helper used to size address fields.
// No ports (package).
// -----------------------------------------------------------------------------
package control_cmd_pkg;

  // Explicit encodings keep the state values stable for anything that
  // decodes them outside this block (debug taps, legacy scripts).
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LINE_ROW   = 3'd1,
    LINE_DATA  = 3'd2,
    CLEAR_ROW  = 3'd3,
    CLEAR_RUN  = 3'd4
  } state_e;

  localparam logic [7:0] CMD_RED_ON      = "R";
  localparam logic [7:0] CMD_RED_OFF     = "r";
  localparam logic [7:0] CMD_GREEN_ON    = "G";
  localparam logic [7:0] CMD_GREEN_OFF   = "g";
  localparam logic [7:0] CMD_BLUE_ON     = "B";
  localparam logic [7:0] CMD_BLUE_OFF    = "b";
  localparam logic [7:0] CMD_LINE        = "L";
  localparam logic [7:0] CMD_CLEAR       = "C";
  localparam logic [7:0] CMD_PLANES_OFF  = "0";
  localparam logic [7:0] CMD_PLANES_ON   = "9";
  localparam logic [7:0] CMD_PLANE_FIRST = "1";
  localparam logic [7:0] CMD_PLANE_LAST  = "8";

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/cmd_gap_timer.sv
// -----------------------------------------------------------------------------
// cmd_gap_timer
// Loadable down-counter that measures the idle gap between received bytes.
// start_i reloads the full gap; every cycle with run_i high and no start
// counts one idle cycle. expired_o is high during the last allowed idle
// cycle, so the owner can abandon its command on that clock edge.
//
// Ports:
//   clk_in     in   clock
//   reset      in   synchronous, active-high
//   start_i    in   reload the counter (a byte was received)
//   run_i      in   owner is waiting for a byte; idle cycles count
//   expired_o  out  gap limit reached in this cycle
// -----------------------------------------------------------------------------
module cmd_gap_timer
  import control_cmd_pkg::*;
#(
  parameter  int CYCLES = 4096,
  localparam int CW     = clog2(CYCLES + 1)
) (
  input  logic clk_in,
  input  logic reset,
  input  logic start_i,
  input  logic run_i,
  output logic expired_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    count_d = count_q;
    if (start_i) begin
      count_d = CW'(CYCLES);
    end else if (run_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  // Count of 1 means this idle cycle is the CYCLES-th one since the reload.
  assign expired_o = run_i && !start_i && (count_q == CW'(1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/control_cmd_engine.sv
// -----------------------------------------------------------------------------
// control_cmd_engine
// Decodes bytes from the UART receiver into RGB channel enables,
// brightness-plane enables and frame-RAM row writes (line load and row clear).
// All outputs except busy are registered: a byte strobed in cycle N takes
// effect in cycle N+1.
//
// Build option: define CONTROL_TIMEOUT_EN to abandon a stalled line/clear
// command after TIMEOUT_CYCLES idle cycles (cmd_abort pulses). Without it the
// engine waits indefinitely and cmd_abort is tied low.
//
// Ports:
//   clk_in             in   clock
//   reset              in   synchronous, active-high
//   rx_data[7:0]       in   received byte, qualified by rx_valid
//   rx_valid           in   one-cycle strobe per byte
//   rgb_enable[2:0]    out  [0]=R [1]=G [2]=B
//   brightness_enable  out  per-plane enable
//   ram_data_out[7:0]  out  frame-RAM write data
//   ram_address        out  frame-RAM write address {row, column byte}
//   ram_write_enable   out  one-cycle write strobe
//   busy               out  engine is inside a multi-byte command
//   cmd_abort          out  one-cycle pulse, command abandoned on timeout
//   rx_overrun         out  one-cycle pulse, byte dropped during row clear
// -----------------------------------------------------------------------------
module control_cmd_engine
  import control_cmd_pkg::*;
#(
  parameter  int PIXEL_COLUMNS    = 64,
  parameter  int BYTES_PER_PIXEL  = 2,
  parameter  int ROW_ADDR_WIDTH   = 5,
  parameter  int BRIGHTNESS_WIDTH = 6,
  parameter  int TIMEOUT_CYCLES   = 4096,
  localparam int COL_BYTES        = PIXEL_COLUMNS * BYTES_PER_PIXEL,
  localparam int COL_ADDR_WIDTH   = clog2(COL_BYTES),
  localparam int RAM_ADDR_WIDTH   = ROW_ADDR_WIDTH + COL_ADDR_WIDTH
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic [2:0]                  rgb_enable,
  output logic [BRIGHTNESS_WIDTH-1:0] brightness_enable,
  output logic [7:0]                  ram_data_out,
  output logic [RAM_ADDR_WIDTH-1:0]   ram_address,
  output logic                        ram_write_enable,
  output logic                        busy,
  output logic                        cmd_abort,
  output logic                        rx_overrun
);

  // Byte index is one bit wider than a column address so the clear run can
  // reach COL_BYTES and spend that cycle leaving, which keeps busy high
  // through the last clear write.
  localparam int                  KW        = COL_ADDR_WIDTH + 1;
  localparam logic [KW-1:0]       K_LAST    = KW'(COL_BYTES - 1);
  localparam logic [KW-1:0]       K_END     = KW'(COL_BYTES);
  // Bytes within a pixel arrive most-significant first; BYTES_PER_PIXEL is a
  // power of two, so BPP-1-(k mod BPP) is just the low bits of k inverted.
  localparam logic [COL_ADDR_WIDTH-1:0] BYTE_FLIP = COL_ADDR_WIDTH'(BYTES_PER_PIXEL - 1);

  state_e                      state_q,  state_d;
  logic [2:0]                  rgb_q,    rgb_d;
  logic [BRIGHTNESS_WIDTH-1:0] bright_q, bright_d;
  logic [ROW_ADDR_WIDTH-1:0]   row_q,    row_d;
  logic [KW-1:0]               k_q,      k_d;
  logic [7:0]                  wdata_q,  wdata_d;
  logic [RAM_ADDR_WIDTH-1:0]   waddr_q,  waddr_d;
  logic                        we_q,     we_d;
  logic                        ovr_q,    ovr_d;
  logic                        timeout_hit;

`ifdef CONTROL_TIMEOUT_EN
  logic gap_run;
  logic abort_q;

  assign gap_run = (state_q == LINE_ROW) || (state_q == LINE_DATA) ||
                   (state_q == CLEAR_ROW);

  cmd_gap_timer #(
    .CYCLES   (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk_in   (clk_in),
    .reset    (reset),
    .start_i  (rx_valid),
    .run_i    (gap_run),
    .expired_o(timeout_hit)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= timeout_hit;
    end
  end

  assign cmd_abort = abort_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
  assign cmd_abort             = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rgb_d    = rgb_q;
    bright_d = bright_q;
    row_d    = row_q;
    k_d      = k_q;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    we_d     = 1'b0;
    ovr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_RED_ON:     rgb_d[0] = 1'b1;
            CMD_RED_OFF:    rgb_d[0] = 1'b0;
            CMD_GREEN_ON:   rgb_d[1] = 1'b1;
            CMD_GREEN_OFF:  rgb_d[1] = 1'b0;
            CMD_BLUE_ON:    rgb_d[2] = 1'b1;
            CMD_BLUE_OFF:   rgb_d[2] = 1'b0;
            CMD_PLANES_OFF: bright_d = '0;
            CMD_PLANES_ON:  bright_d = '1;
            CMD_LINE:       state_d  = LINE_ROW;
            CMD_CLEAR:      state_d  = CLEAR_ROW;
            default: begin
              // Digit n toggles plane BRIGHTNESS_WIDTH-n; digits beyond the
              // plane count select no index and are ignored.
              if ((rx_data >= CMD_PLANE_FIRST) && (rx_data <= CMD_PLANE_LAST)) begin
                for (int p = 0; p < BRIGHTNESS_WIDTH; p++) begin
                  if (p == BRIGHTNESS_WIDTH - (int'(rx_data) - int'(CMD_PLANES_OFF))) begin
                    bright_d[p] = ~bright_q[p];
                  end
                end
              end
            end
          endcase
        end
      end

      LINE_ROW: begin
        // A repeated 'L' re-arms; anything else is the row number.
        if (rx_valid && (rx_data != CMD_LINE)) begin
          row_d   = rx_data[ROW_ADDR_WIDTH-1:0];
          k_d     = '0;
          state_d = LINE_DATA;
        end
      end

      LINE_DATA: begin
        if (rx_valid) begin
          we_d    = 1'b1;
          wdata_d = rx_data;
          waddr_d = {row_q, k_q[COL_ADDR_WIDTH-1:0] ^ BYTE_FLIP};
          k_d     = k_q + KW'(1);
          if (k_q == K_LAST) begin
            state_d = IDLE;
          end
        end
      end

      CLEAR_ROW: begin
        if (rx_valid) begin
          row_d   = rx_data[ROW_ADDR_WIDTH-1:0];
          k_d     = '0;
          state_d = CLEAR_RUN;
        end
      end

      CLEAR_RUN: begin
        ovr_d = rx_valid;
        if (k_q == K_END) begin
          state_d = IDLE;
        end else begin
          we_d    = 1'b1;
          wdata_d = 8'h00;
          waddr_d = {row_q, k_q[COL_ADDR_WIDTH-1:0]};
          k_d     = k_q + KW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Timeout only fires in cycles without a byte, so it never races a write.
    if (timeout_hit) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= IDLE;
      rgb_q    <= 3'b111;
      bright_q <= '1;
      row_q    <= '0;
      k_q      <= '0;
      wdata_q  <= '0;
      waddr_q  <= '0;
      we_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rgb_q    <= rgb_d;
      bright_q <= bright_d;
      row_q    <= row_d;
      k_q      <= k_d;
      wdata_q  <= wdata_d;
      waddr_q  <= waddr_d;
      we_q     <= we_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rgb_enable        = rgb_q;
  assign brightness_enable = bright_q;
  assign ram_data_out      = wdata_q;
  assign ram_address       = waddr_q;
  assign ram_write_enable  = we_q;
  assign rx_overrun        = ovr_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_control_cmd_engine.sv
// -----------------------------------------------------------------------------
// tb_control_cmd_engine
// Directed bench for control_cmd_engine (64 columns x 2 bytes, 5 row bits,
// 6 planes, TIMEOUT_CYCLES=16). Expected RAM writes go into a scoreboard
// queue as stimulus is issued; a negedge monitor pops and compares each
// write the DUT presents. Timeout scenario runs when CONTROL_TIMEOUT_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_control_cmd_engine;

  logic        clk_in   = 1'b0;
  logic        reset    = 1'b1;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_valid = 1'b0;
  logic [2:0]  rgb_enable;
  logic [5:0]  brightness_enable;
  logic [7:0]  ram_data_out;
  logic [11:0] ram_address;
  logic        ram_write_enable;
  logic        busy;
  logic        cmd_abort;
  logic        rx_overrun;

  control_cmd_engine #(
    .PIXEL_COLUMNS    (64),
    .BYTES_PER_PIXEL  (2),
    .ROW_ADDR_WIDTH   (5),
    .BRIGHTNESS_WIDTH (6),
    .TIMEOUT_CYCLES   (16)
  ) dut (
    .clk_in            (clk_in),
    .reset             (reset),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rgb_enable        (rgb_enable),
    .brightness_enable (brightness_enable),
    .ram_data_out      (ram_data_out),
    .ram_address       (ram_address),
    .ram_write_enable  (ram_write_enable),
    .busy              (busy),
    .cmd_abort         (cmd_abort),
    .rx_overrun        (rx_overrun)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         exp_e;
  int          wr_cyc[$];
  int          checks      = 0;
  int          errors      = 0;
  int          wr_count    = 0;
  int          overrun_cnt = 0;
  int          abort_cnt   = 0;
  int          cycle       = 0;
  logic [11:0] last_addr   = '0;
  logic [7:0]  last_data   = '0;
  int          wc0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_in) cycle <= cycle + 1;

  // Monitor: pulse counters plus scoreboard compare of every RAM write.
  always @(negedge clk_in) begin
    if (rx_overrun === 1'b1) overrun_cnt++;
    if (cmd_abort === 1'b1)  abort_cnt++;
    if (ram_write_enable === 1'b1) begin
      wr_count++;
      wr_cyc.push_back(cycle);
      last_addr = ram_address;
      last_data = ram_data_out;
      if (exp_q.size() == 0) begin
        check("unexpected_write_sb_depth", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", 32'(ram_address), 32'(exp_e.addr));
        check("wr_data", 32'(ram_data_out), 32'(exp_e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Byte is held for exactly one sampling edge; consecutive calls are
  // back-to-back strobes.
  task automatic send(input logic [7:0] b);
    tick();
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      rx_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    tick();
    reset    = 1'b1;
    rx_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Line byte k of a row: pixel k/2, high byte (k even) at the odd address.
  task automatic push_line(input int row, input int k, input logic [7:0] d);
    wr_t w;
    w.addr = 12'(row * 128 + (k / 2) * 2 + (1 - (k % 2)));
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic push_clear(input int row, input int k);
    wr_t w;
    w.addr = 12'(row * 128 + k);
    w.data = 8'h00;
    exp_q.push_back(w);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rgb"},    32'(rgb_enable),        32'h7);
    check({tag, "_bright"}, 32'(brightness_enable), 32'h3F);
    check({tag, "_data"},   32'(ram_data_out),      32'h0);
    check({tag, "_addr"},   32'(ram_address),       32'h0);
    check({tag, "_we"},     32'(ram_write_enable),  32'h0);
    check({tag, "_busy"},   32'(busy),              32'h0);
    check({tag, "_abort"},  32'(cmd_abort),         32'h0);
    check({tag, "_ovr"},    32'(rx_overrun),        32'h0);
  endtask

  initial begin
    // ---- reset state ----
    do_reset();
    check_reset_values("reset");

    // ---- colour / brightness commands ----
    send("r"); send("g"); send("3"); idle(1);
    check("cmd_rgb_rg",   32'(rgb_enable),        32'h4);
    check("cmd_bright_3", 32'(brightness_enable), 32'h37);
    send("9"); idle(1);
    check("cmd_bright_9", 32'(brightness_enable), 32'h3F);
    send("0"); send("7"); idle(1);
    check("cmd_bright_0_7", 32'(brightness_enable), 32'h00);
    send("1"); idle(1);
    check("cmd_bright_1", 32'(brightness_enable), 32'h20);
    send("6"); send("x"); idle(1);
    check("cmd_bright_6", 32'(brightness_enable), 32'h21);
    check("cmd_ignored_busy", 32'(busy), 32'h0);
    send("9"); idle(1);

    // ---- line write, row 5, data 0x00..0x7F ----
    send("L");
    send(8'h05);
    for (int k = 0; k < 128; k++) begin
      push_line(5, k, 8'(k));
      send(8'(k));
      if (k == 64) check("line1_busy_mid", 32'(busy), 32'h1);
    end
    idle(1);
    check("line1_busy_end",  32'(busy),      32'h0);
    idle(1);
    check("line1_sb_empty",  32'(exp_q.size()), 32'h0);
    check("line1_last_addr", 32'(last_addr),    32'd766);
    check("line1_last_data", 32'(last_data),    32'h7F);

    // ---- re-armed line, row 3, command right after the last byte ----
    send("L");
    send("L");
    send(8'h03);
    for (int k = 0; k < 128; k++) begin
      push_line(3, k, 8'(8'hA0 ^ k));
      send(8'(8'hA0 ^ k));
    end
    send("b");
    idle(1);
    check("line2_cmd_after", 32'(rgb_enable),   32'h0);
    check("line2_sb_empty",  32'(exp_q.size()), 32'h0);
    check("line2_last_addr", 32'(last_addr),    32'd510);

    // ---- row clear, row 2, byte injected mid-run ----
    wc0 = wr_count;
    for (int k = 0; k < 128; k++) push_clear(2, k);
    send("C");
    send(8'h02);
    idle(20);
    check("clear_busy_mid", 32'(busy), 32'h1);
    send("R");
    idle(140);
    check("clear_count",       32'(wr_count - wc0), 32'd128);
    check("clear_consecutive", 32'(wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-128]), 32'd127);
    check("clear_sb_empty",    32'(exp_q.size()),   32'h0);
    check("clear_overrun",     32'(overrun_cnt),    32'd1);
    check("clear_byte_dropped", 32'(rgb_enable),    32'h0);
    check("clear_busy_end",    32'(busy),           32'h0);

`ifdef CONTROL_TIMEOUT_EN
    // ---- stalled line: abort after 16 idle cycles ----
    send("L");
    send(8'h01);
    for (int k = 0; k < 10; k++) begin
      push_line(1, k, 8'(8'h50 + k));
      send(8'(8'h50 + k));
    end
    idle(16);
    check("to_busy_before",  32'(busy),      32'h1);
    check("to_no_abort_yet", 32'(abort_cnt), 32'h0);
    idle(1);
    check("to_abort_pulse",  32'(cmd_abort), 32'h1);
    check("to_busy_after",   32'(busy),      32'h0);
    idle(1);
    check("to_abort_one_cycle", 32'(cmd_abort), 32'h0);
    check("to_abort_count",     32'(abort_cnt), 32'd1);
    check("to_sb_empty",        32'(exp_q.size()), 32'h0);
    send("R");
    idle(1);
    check("to_cmd_after", 32'(rgb_enable), 32'h1);
`endif

    // ---- reset after the 40th line byte ----
    send("L");
    send(8'h07);
    for (int k = 0; k < 40; k++) begin
      push_line(7, k, 8'(8'hC0 + k));
      send(8'(8'hC0 + k));
    end
    do_reset();
    check_reset_values("midreset");
    check("midreset_sb_empty", 32'(exp_q.size()), 32'h0);
    wc0 = wr_count;
    send(8'h55);
    send(8'h12);
    idle(10);
    check("midreset_no_writes", 32'(wr_count - wc0), 32'h0);
    send("L");
    send(8'h01);
    push_line(1, 0, 8'hE1);
    send(8'hE1);
    push_line(1, 1, 8'hE2);
    send(8'hE2);
    idle(3);
    check("midreset_new_line", 32'(wr_count - wc0), 32'd2);
    check("midreset_busy",     32'(busy),           32'h1);

    // ---- final tallies ----
    check("final_sb_empty", 32'(exp_q.size()), 32'h0);
    check("final_overrun",  32'(overrun_cnt),  32'd1);
`ifdef CONTROL_TIMEOUT_EN
    check("final_abort",    32'(abort_cnt),    32'd1);
`else
    check("final_abort",    32'(abort_cnt),    32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_cmd_engine.md
# control_cmd_engine

Parametrised command decoder between the UART byte receiver and the panel frame RAM / display-control path. It consumes one received byte per strobe and does three things: sets the RGB channel enables, sets the brightness-plane enables, and streams a row of pixel bytes into frame RAM. Unlike the previous generation it is fully synchronous to one clock, supports configurable panel width, pixel size and brightness depth, adds a row-clear command, and reports abort/overrun status.

## Interface
- PIXEL_COLUMNS, 64, pixels per row; power of two.
- BYTES_PER_PIXEL, 2, bytes per pixel; power of two, 1..4.
- ROW_ADDR_WIDTH, 5, row address bits.
- BRIGHTNESS_WIDTH, 6, brightness planes; 1..8.
- TIMEOUT_CYCLES, 4096, inter-byte gap limit. Used only with CONTROL_TIMEOUT_EN.
- Derived values:
  - COL_BYTES = PIXEL_COLUMNS*BYTES_PER_PIXEL.
  - COL_ADDR_WIDTH = clog2(COL_BYTES).
  - RAM_ADDR_WIDTH = ROW_ADDR_WIDTH+COL_ADDR_WIDTH.

Ports (clock and reset first):
- clk_in  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  received byte; qualified by rx_valid.
- rx_valid  in  1  one-cycle strobe, one per byte.
- rgb_enable  out  3  [0]=R, [1]=G, [2]=B.
- brightness_enable  out  BRIGHTNESS_WIDTH  per-plane enable.
- ram_data_out  out  8  write data.
- ram_address  out  RAM_ADDR_WIDTH  write address.
- ram_write_enable  out  1  one-cycle write strobe.
- busy  out  1  high in any state other than IDLE.
- cmd_abort  out  1  one-cycle pulse when a command is abandoned.
- rx_overrun  out  1  one-cycle pulse when a byte is dropped.

## Operation
- Reset values: state IDLE; rgb_enable 3'b111; brightness_enable all ones; ram_data_out 0; ram_address 0; ram_write_enable, busy, cmd_abort, rx_overrun all 0.
- In IDLE each valid byte is decoded as a command:
  - 'R'/'G'/'B' set rgb_enable[0]/[1]/[2]; 'r'/'g'/'b' clear them.
  - '1'..'8' toggle brightness_enable[BRIGHTNESS_WIDTH-n] when n ≤ BRIGHTNESS_WIDTH; otherwise the byte is ignored.
  - '0' clears all brightness planes; '9' sets all of them.
  - 'L' goes to LINE_ROW; 'C' goes to CLEAR_ROW.
  - Any other byte is ignored.
- LINE_ROW, on a valid byte:
  - 'L' re-arms: stays in LINE_ROW, no row is latched.
  - Any other byte latches row = rx_data[ROW_ADDR_WIDTH-1:0], clears byte index k, and moves to LINE_DATA.
- LINE_DATA, on valid byte number k (k = 0..COL_BYTES-1):
  - Writes the byte at address {row, k/BYTES_PER_PIXEL, BYTES_PER_PIXEL-1-(k mod BYTES_PER_PIXEL)}. Pixels ascend; bytes arrive most-significant first.
  - After k = COL_BYTES-1, returns to IDLE.
- CLEAR_ROW, on a valid byte: latches row, goes to CLEAR_RUN.
- CLEAR_RUN:
  - Writes 0x00 to every byte of the row, one per cycle, ascending, COL_BYTES cycles total, then returns to IDLE.
  - Any rx_valid during CLEAR_RUN drops the byte and pulses rx_overrun.
- Arithmetic: k is COL_ADDR_WIDTH+1 bits wide and never wraps across rows. Row values at or above 2^ROW_ADDR_WIDTH are truncated by the bit slice.

## Timing
- Command latency: rx_valid in cycle N makes the enable change visible in cycle N+1.
- Write latency: rx_valid in cycle N makes ram_write_enable high in cycle N+1, with ram_data_out and ram_address valid in that same cycle. The strobe lasts exactly one cycle; address and data hold until the next write.
- Back-to-back rx_valid on consecutive cycles is accepted with no loss, except during CLEAR_RUN.
- Final data byte: the write and the return to IDLE happen together. A byte arriving in the next cycle is decoded as a command.
- Clear timing: CLEAR_RUN issues its first write in the cycle after the row byte is registered, and its last write in cycle COL_BYTES after that. busy falls in the cycle after the last write.
- Reset has priority over rx_valid and over any in-progress write. A reset mid-line drops the partial line with no further writes and no cmd_abort.

## Configuration
- CONTROL_TIMEOUT_EN defined:
  - A gap counter runs in LINE_ROW, LINE_DATA and CLEAR_ROW and restarts on every accepted byte.
  - After TIMEOUT_CYCLES idle cycles the state returns to IDLE and cmd_abort pulses for one cycle.
  - Writes already issued stand.
- CONTROL_TIMEOUT_EN undefined: the engine waits indefinitely and cmd_abort is tied to 0.

## Structure
- Shared package control_cmd_pkg holds:
  - the state enum (IDLE, LINE_ROW, LINE_DATA, CLEAR_ROW, CLEAR_RUN);
  - the command-character localparams;
  - a clog2 helper.
- One sub-module, cmd_gap_timer: a loadable down-counter with a start input and an expired output. It is instantiated only under CONTROL_TIMEOUT_EN.

## Test plan
- Reset, then 'r', 'g', '3' → rgb_enable 3'b100, brightness_enable 6'b110111. Then '9' → 6'b111111.
- 'L', 0x05, then 128 bytes 0x00..0x7F (defaults) → 128 writes. First write: address 641, data 0x00. Second: address 640, data 0x01. Last: address 766, data 0x7F. Then busy=0.
- 'L', 'L', 0x03, 128 bytes → all writes go to row 3 (addresses 384..511).
- 'C', 0x02 → 128 consecutive writes of 0x00 at addresses 256..383. A byte injected mid-clear → rx_overrun pulse and no extra write.
- With CONTROL_TIMEOUT_EN and TIMEOUT_CYCLES=16: 'L', 0x01, 10 bytes, then silence → cmd_abort pulse after 16 idle cycles. A following 'R' is decoded as a command.
- Reset asserted after the 40th line byte → outputs return to reset values; no further writes until a new 'L'.
